intc_request_ctrl: RTL and testbench

- Device-side interrupt controller: the requesting end of the CPU interrupt handshake.
- Collects N_IRQ maskable device lines plus one non-maskable line.
- Drives interrupt / non_maskable_int into the multi-cycle MIPS interrupt-state logic and waits for its respond/NMI acknowledge.
- Presents the cause id to the ISR; tracks in-service status until end-of-interrupt (eoi, issued by the core on eret).

---
 rtl/intc_pkg.sv | 21 ++
 rtl/intc_request_ctrl_if.sv | 52 +++++
 rtl/intc_prio_enc.sv | 30 +++
 rtl/intc_request_ctrl.sv | 178 +++++++++++++++++
 tb/tb_intc_request_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt request controller:
//   - state_e    : controller FSM encoding (also visible on the debug port)
//   - N_IRQ_DEF  : default number of maskable interrupt lines
//   - ID_W_DEF   : default width of the cause id
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package intc_pkg;

    localparam int N_IRQ_DEF = 8;
    localparam int ID_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_SERV     = 2'd2,
        ST_NMI_SERV = 2'd3
    } state_e;

endpackage

// File: rtl/intc_request_ctrl_if.sv
// ---------------------------------------------------------------------------
// intc_request_ctrl_if
// Bundles the device request lines, the CPU handshake and the status
// outputs of the interrupt request controller.
//   slave  : the controller (consumes requests/acks, drives status)
//   master : devices + CPU (drive requests/acks, observe status)
// Signals:
//   irq_in, nmi_in         device request lines
//   mask_wr, mask_data     enable-mask write port
//   respond, NMI, eoi      CPU acknowledge / end-of-interrupt
//   interrupt,
//   non_maskable_int       requests to the CPU
//   busy, cause_id,
//   cause_valid, pending,
//   state                  status / debug
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface intc_request_ctrl_if
    import intc_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int ID_W  = ID_W_DEF
);

    logic [N_IRQ-1:0] irq_in;
    logic             nmi_in;
    logic             mask_wr;
    logic [N_IRQ-1:0] mask_data;
    logic             respond;
    logic             NMI;
    logic             eoi;
    logic             interrupt;
    logic             non_maskable_int;
    logic             busy;
    logic [ID_W-1:0]  cause_id;
    logic             cause_valid;
    logic [N_IRQ-1:0] pending;
    logic [1:0]       state;

    modport slave (
        input  irq_in, nmi_in, mask_wr, mask_data, respond, NMI, eoi,
        output interrupt, non_maskable_int, busy, cause_id, cause_valid,
               pending, state
    );

    modport master (
        output irq_in, nmi_in, mask_wr, mask_data, respond, NMI, eoi,
        input  interrupt, non_maskable_int, busy, cause_id, cause_valid,
               pending, state
    );

endinterface

// File: rtl/intc_prio_enc.sv
// ---------------------------------------------------------------------------
// intc_prio_enc
// Combinational lowest-index-first priority encoder.
//   req_i   : request vector
//   id_o    : index of the lowest set bit (0 when none set)
//   valid_o : at least one request bit is set
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module intc_prio_enc #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        id_o = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/intc_request_ctrl.sv
// ---------------------------------------------------------------------------
// intc_request_ctrl
// Device-side interrupt controller. Latches device request edges, masks
// them, raises interrupt / non_maskable_int towards the CPU, waits for the
// respond/NMI acknowledge and tracks the in-service interrupt until eoi.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : intc_request_ctrl_if.slave (requests, handshake, status)
// Build option:
//   INTC_LEVEL_TRIG_EN  when defined, maskable lines are level-sensitive
//                       (pending mirrors irq_in); NMI stays edge-triggered.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module intc_request_ctrl
    import intc_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    intc_request_ctrl_if.slave    bus
);

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] mask_q;
    logic             nmi_prev_q;
    logic             nmi_pend_q, nmi_pend_d;
    logic             nested_q, nested_d;
    logic [ID_W-1:0]  cause_q, cause_d;

    logic [N_IRQ-1:0] pending_w;
    logic [N_IRQ-1:0] active_w;
    logic [ID_W-1:0]  enc_id;
    logic             enc_valid;
    logic             req_int;
    logic             nmi_ack;
    logic             int_ack;

    // ---------------------------------------------------------------------
    // Pending capture
    // ---------------------------------------------------------------------
`ifdef INTC_LEVEL_TRIG_EN
    // Level mode: the device holds its line until serviced; gated by reset
    // so the status outputs read zero while reset is asserted.
    assign pending_w = bus.irq_in & {N_IRQ{~reset}};
`else
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] clr_vec;

    assign irq_rise = bus.irq_in & ~irq_prev_q;

    // Only the line being acknowledged is cleared.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_clr
        assign clr_vec[gi] = int_ack && (enc_id == ID_W'(gi));
    end

    // A fresh edge on the line being acknowledged wins over the clear.
    assign pend_d = (pend_q & ~clr_vec) | irq_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            pend_q     <= pend_d;
            irq_prev_q <= bus.irq_in;
        end
    end

    assign pending_w = pend_q;
`endif

    assign active_w = pending_w & mask_q;

    intc_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i   (active_w),
        .id_o    (enc_id),
        .valid_o (enc_valid)
    );

    // ---------------------------------------------------------------------
    // Handshake qualification
    // ---------------------------------------------------------------------
    // A pending NMI suppresses the maskable request so the CPU sees one
    // request kind at a time.
    assign req_int = (state_q == ST_REQ) && enc_valid && !nmi_pend_q;

    // Acks without a matching outstanding request are ignored.
    assign nmi_ack = bus.respond && bus.NMI && nmi_pend_q &&
                     ((state_q == ST_REQ) || (state_q == ST_SERV));
    assign int_ack = bus.respond && !bus.NMI && req_int;

    assign nmi_pend_d = (nmi_pend_q && !nmi_ack) || (bus.nmi_in && !nmi_prev_q);

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        nested_d = nested_q;
        cause_d  = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (nmi_pend_q || enc_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (nmi_ack) begin
                    state_d  = ST_NMI_SERV;
                    nested_d = 1'b0;
                end else if (int_ack) begin
                    state_d = ST_SERV;
                    cause_d = enc_id;
                end else if (!nmi_pend_q && !enc_valid) begin
                    // Request withdrawn by a mask write.
                    state_d = ST_IDLE;
                end
            end
            ST_SERV: begin
                // NMI preemption takes priority over a same-cycle eoi.
                if (nmi_ack) begin
                    state_d  = ST_NMI_SERV;
                    nested_d = 1'b1;
                end else if (bus.eoi) begin
                    state_d = ST_IDLE;
                end
            end
            ST_NMI_SERV: begin
                if (bus.eoi) begin
                    state_d = nested_q ? ST_SERV : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            nested_q   <= 1'b0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            nmi_prev_q <= bus.nmi_in;
            nmi_pend_q <= nmi_pend_d;
            nested_q   <= nested_d;
            cause_q    <= cause_d;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.interrupt        = req_int;
    assign bus.non_maskable_int = nmi_pend_q && (state_q != ST_NMI_SERV);
    assign bus.busy             = (state_q == ST_SERV) || (state_q == ST_NMI_SERV);
    assign bus.cause_valid      = (state_q == ST_SERV);
    // While requesting, the id follows the encoder; once acknowledged it is
    // frozen so later mask writes or new edges cannot disturb the ISR.
    assign bus.cause_id         = (state_q == ST_REQ) ? enc_id : cause_q;
    assign bus.pending          = pending_w;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_intc_request_ctrl.sv
`timescale 1ns/1ps
module tb_intc_request_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    intc_request_ctrl_if #(.N_IRQ(N), .ID_W(IW)) bus ();

    intc_request_ctrl #(.N_IRQ(N), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        bus.mask_wr   = 1'b1;
        bus.mask_data = m;
        step(1);
        bus.mask_wr   = 1'b0;
    endtask

    task automatic do_respond(input logic nmi);
        bus.respond = 1'b1;
        bus.NMI     = nmi;
        step(1);
        bus.respond = 1'b0;
        bus.NMI     = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1;
        step(1);
        bus.eoi = 1'b0;
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++;
        if ({bus.interrupt, bus.non_maskable_int, bus.busy, bus.cause_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000",
                {bus.interrupt, bus.non_maskable_int, bus.busy, bus.cause_valid});
        end
        checks++;
        if (bus.pending !== 8'h00 || bus.state !== 2'd0 || bus.cause_id !== 3'd0) begin
            errors++; $display("FAIL reset_state: pending=%h state=%0d cause=%0d want 0/0/0",
                bus.pending, bus.state, bus.cause_id);
        end
        reset = 1'b0;
        step(1);
        $display("txn reset done");
    endtask

    task automatic test_basic();
        write_mask(8'hFF);
        bus.irq_in = 8'h20;
        step(1);
        bus.irq_in = 8'h00;
        checks++;
        if (bus.pending !== 8'h20 || bus.interrupt !== 1'b0) begin
            errors++; $display("FAIL basic_latency1: pending=%h int=%b want 20/0", bus.pending, bus.interrupt);
        end
        step(1);
        checks++;
        if (bus.interrupt !== 1'b1 || bus.cause_id !== 3'd5) begin
            errors++; $display("FAIL basic_req: int=%b cause=%0d want 1/5", bus.interrupt, bus.cause_id);
        end
        step(3);
        checks++;
        if (bus.interrupt !== 1'b1) begin
            errors++; $display("FAIL basic_hold: int=%b want 1", bus.interrupt);
        end
        do_respond(1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.cause_valid !== 1'b1 || bus.pending[5] !== 1'b0 || bus.interrupt !== 1'b0) begin
            errors++; $display("FAIL basic_serv: busy=%b cv=%b pend=%h int=%b want 1/1/00/0",
                bus.busy, bus.cause_valid, bus.pending, bus.interrupt);
        end
        do_eoi();
        checks++;
        if (bus.state !== 2'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_eoi: state=%0d busy=%b want 0/0", bus.state, bus.busy);
        end
        $display("txn basic request line 5 done");
    endtask

    task automatic test_priority();
        bus.irq_in = 8'h44;
        step(1);
        bus.irq_in = 8'h00;
        step(1);
        checks++;
        if (bus.interrupt !== 1'b1 || bus.cause_id !== 3'd2) begin
            errors++; $display("FAIL prio_first: int=%b cause=%0d want 1/2", bus.interrupt, bus.cause_id);
        end
        do_respond(1'b0);
        do_eoi();
        step(1);
        checks++;
        if (bus.interrupt !== 1'b1 || bus.cause_id !== 3'd6) begin
            errors++; $display("FAIL prio_second: int=%b cause=%0d want 1/6", bus.interrupt, bus.cause_id);
        end
        do_respond(1'b0);
        do_eoi();
        $display("txn priority 2 then 6 done");
    endtask

    task automatic test_masking();
        write_mask(8'h00);
        bus.irq_in = 8'h08;
        step(1);
        bus.irq_in = 8'h00;
        step(2);
        checks++;
        if (bus.pending !== 8'h08 || bus.interrupt !== 1'b0) begin
            errors++; $display("FAIL mask_block: pending=%h int=%b want 08/0", bus.pending, bus.interrupt);
        end
        write_mask(8'h08);
        for (int c = 0; c < 2 && bus.interrupt !== 1'b1; c++) step(1);
        checks++;
        if (bus.interrupt !== 1'b1 || bus.cause_id !== 3'd3) begin
            errors++; $display("FAIL mask_enable: int=%b cause=%0d want 1/3", bus.interrupt, bus.cause_id);
        end
        do_respond(1'b0);
        do_eoi();
        write_mask(8'hFF);
        $display("txn masking line 3 done");
    endtask

    task automatic test_nmi();
        bus.irq_in = 8'h10;
        step(1);
        bus.irq_in = 8'h00;
        step(1);
        do_respond(1'b0);
        checks++;
        if (bus.state !== 2'd2 || bus.cause_id !== 3'd4) begin
            errors++; $display("FAIL nmi_setup: state=%0d cause=%0d want 2/4", bus.state, bus.cause_id);
        end
        do_respond(1'b1);   // no NMI outstanding: must be ignored
        checks++;
        if (bus.state !== 2'd2) begin
            errors++; $display("FAIL nmi_stray_ack: state=%0d want 2", bus.state);
        end
        bus.nmi_in = 1'b1;
        step(1);
        bus.nmi_in = 1'b0;
        checks++;
        if (bus.non_maskable_int !== 1'b1) begin
            errors++; $display("FAIL nmi_raise: nmi=%b want 1", bus.non_maskable_int);
        end
        bus.eoi = 1'b1;     // collides with the NMI ack; ack wins
        do_respond(1'b1);
        bus.eoi = 1'b0;
        checks++;
        if (bus.state !== 2'd3 || bus.non_maskable_int !== 1'b0 || bus.busy !== 1'b1 || bus.cause_valid !== 1'b0) begin
            errors++; $display("FAIL nmi_serv: state=%0d nmi=%b busy=%b cv=%b want 3/0/1/0",
                bus.state, bus.non_maskable_int, bus.busy, bus.cause_valid);
        end
        do_eoi();
        checks++;
        if (bus.state !== 2'd2 || bus.cause_id !== 3'd4 || bus.cause_valid !== 1'b1) begin
            errors++; $display("FAIL nmi_return: state=%0d cause=%0d cv=%b want 2/4/1",
                bus.state, bus.cause_id, bus.cause_valid);
        end
        do_eoi();
        checks++;
        if (bus.state !== 2'd0) begin
            errors++; $display("FAIL nmi_idle: state=%0d want 0", bus.state);
        end
        $display("txn nmi preemption done");
    endtask

    task automatic test_collision();
        bus.irq_in = 8'h02;
        step(1);
        bus.irq_in = 8'h00;
        step(1);
        bus.irq_in = 8'h02;
        do_respond(1'b0);
        bus.irq_in = 8'h00;
        checks++;
        if (bus.state !== 2'd2 || bus.pending[1] !== 1'b1) begin
            errors++; $display("FAIL coll_setwins: state=%0d pend=%h want 2/02", bus.state, bus.pending);
        end
        do_eoi();
        step(1);
        checks++;
        if (bus.interrupt !== 1'b1 || bus.cause_id !== 3'd1) begin
            errors++; $display("FAIL coll_rerequest: int=%b cause=%0d want 1/1", bus.interrupt, bus.cause_id);
        end
        do_respond(1'b0);
        do_eoi();
        $display("txn same-cycle collision done");
    endtask

    task automatic test_async_reset();
        bus.irq_in = 8'h01;
        step(1);
        bus.irq_in = 8'h00;
        step(1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.interrupt, bus.non_maskable_int, bus.busy, bus.cause_valid} !== 4'b0 ||
            bus.state !== 2'd0 || bus.pending !== 8'h00) begin
            errors++; $display("FAIL async_reset: int=%b state=%0d pend=%h want 0/0/00",
                bus.interrupt, bus.state, bus.pending);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(3);
        checks++;
        if (bus.interrupt !== 1'b0 || bus.state !== 2'd0 || bus.pending !== 8'h00) begin
            errors++; $display("FAIL async_reset_clean: int=%b state=%0d pend=%h want 0/0/00",
                bus.interrupt, bus.state, bus.pending);
        end
        $display("txn async reset done");
    endtask

    // Transaction-level model: pending is a set of line numbers, the CPU
    // always serves the lowest enabled one, masked lines stay pending.
    task automatic test_random();
        logic [N-1:0] mdl_pend;
        logic [N-1:0] mdl_mask;
        logic [N-1:0] v;
        int           exp_id;
        mdl_pend = '0;
        for (int t = 0; t < 30; t++) begin
            mdl_mask = N'($urandom);
            write_mask(mdl_mask);
            v = N'($urandom);
            bus.irq_in = v;
            step(1);
            bus.irq_in = '0;
            mdl_pend = mdl_pend | v;
            checks++;
            if (bus.pending !== mdl_pend) begin
                errors++; $display("FAIL rnd_pending: t=%0d got %h want %h", t, bus.pending, mdl_pend);
            end
            while ((mdl_pend & mdl_mask) != '0) begin
                exp_id = lowest(mdl_pend & mdl_mask);
                for (int c = 0; c < 4 && bus.interrupt !== 1'b1; c++) step(1);
                checks++;
                if (bus.interrupt !== 1'b1 || bus.cause_id !== IW'(exp_id)) begin
                    errors++; $display("FAIL rnd_request: t=%0d int=%b cause=%0d want 1/%0d",
                        t, bus.interrupt, bus.cause_id, exp_id);
                    break;
                end
                do_respond(1'b0);
                mdl_pend[exp_id] = 1'b0;
                checks++;
                if (bus.busy !== 1'b1 || bus.pending !== mdl_pend) begin
                    errors++; $display("FAIL rnd_serv: t=%0d busy=%b pend=%h want 1/%h",
                        t, bus.busy, bus.pending, mdl_pend);
                end
                do_eoi();
            end
            step(2);
            checks++;
            if (bus.interrupt !== 1'b0 || bus.state !== 2'd0 || bus.pending !== mdl_pend) begin
                errors++; $display("FAIL rnd_idle: t=%0d int=%b state=%0d pend=%h want 0/0/%h",
                    t, bus.interrupt, bus.state, bus.pending, mdl_pend);
            end
            $display("txn random %0d mask=%h irq=%h left=%h", t, mdl_mask, v, mdl_pend);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.irq_in    = '0;
        bus.nmi_in    = 1'b0;
        bus.mask_wr   = 1'b0;
        bus.mask_data = '0;
        bus.respond   = 1'b0;
        bus.NMI       = 1'b0;
        bus.eoi       = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_nmi();
        test_collision();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
